// File: rtl/mult_pkg.sv
// +----------------------------------------------------------------------------+
// | mult_pkg : shared types and constants for the sequential multiplier        |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MULT_WIDTH = 4;

    // Counter must hold WIDTH itself, hence WIDTH+1 codes.
    function automatic int count_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_multiplier_if.sv
// +----------------------------------------------------------------------------+
// | seq_multiplier_if : start/done handshake and operand/result bus            |
// | Revision          : 1.0                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface seq_multiplier_if #(
    parameter int WIDTH = 4
);

    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start,
        output a,
        output b,
        input  busy,
        input  done,
        input  product
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        output busy,
        output done,
        output product
    );

endinterface

`default_nettype wire

// File: rtl/ripple_adder.sv
// +----------------------------------------------------------------------------+
// | ripple_adder : WIDTH-bit ripple-carry adder built from full-adder cells    |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module ripple_adder #(
    parameter int WIDTH = 4
) (
    input  wire logic [WIDTH-1:0] x,
    input  wire logic [WIDTH-1:0] y,
    input  wire logic             cin,
    output logic      [WIDTH-1:0] sum,
    output logic                  cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i]     = x[i] ^ y[i] ^ carry[i];
        assign carry[i+1] = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
    end

    assign cout = carry[WIDTH];

endmodule

`default_nettype wire

// File: rtl/seq_multiplier.sv
// +----------------------------------------------------------------------------+
// | seq_multiplier : shift-and-add multiplier, WIDTH add/shift cycles per op   |
// | Option         : SEQ_MULT_SIGNED_EN selects two's-complement operands      |
// | Revision       : 1.0                                                       |
// +----------------------------------------------------------------------------+
`default_nettype none

module seq_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  wire logic        clk,
    input  wire logic        reset_n,
    seq_multiplier_if.slave  bus
);

    localparam int               CNT_W      = count_width(WIDTH);
    localparam logic [CNT_W-1:0] COUNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] COUNT_LAST = CNT_W'(1);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     mplr_q, mplr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [WIDTH-1:0]     add_y;
    logic [WIDTH-1:0]     add_sum;
    logic                 add_cout;
    logic [2*WIDTH:0]     shift_in;
    logic [2*WIDTH-1:0]   shifted;
    logic [WIDTH-1:0]     cap_mcand;
    logic [WIDTH-1:0]     cap_mplr;
    logic [2*WIDTH-1:0]   final_product;

`ifdef SEQ_MULT_SIGNED_EN
    logic sign_q, sign_d;

    // Negating -2^(WIDTH-1) wraps back to the same bit pattern, which read
    // unsigned is exactly its magnitude.
    assign cap_mcand     = bus.a[WIDTH-1] ? (~bus.a + 1'b1) : bus.a;
    assign cap_mplr      = bus.b[WIDTH-1] ? (~bus.b + 1'b1) : bus.b;
    assign sign_d        = (state_q == IDLE && bus.start) ? (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]) : sign_q;
    assign final_product = sign_q ? (~shifted + 1'b1) : shifted;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sign_q <= 1'b0;
        else          sign_q <= sign_d;
    end
`else
    assign cap_mcand     = bus.a;
    assign cap_mplr      = bus.b;
    assign final_product = shifted;
`endif

    assign add_y = mplr_q[0] ? mcand_q : '0;

    ripple_adder #(.WIDTH(WIDTH)) u_adder (
        .x    (acc_q),
        .y    (add_y),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Carry joins the top of the shift so the accumulator never loses a bit.
    assign shift_in = {add_cout, add_sum, mplr_q};
    assign shifted  = shift_in[2*WIDTH:1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (count_q == COUNT_LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        mplr_d    = mplr_q;
        count_d   = count_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mcand_d = cap_mcand;
                    acc_d   = '0;
                    mplr_d  = cap_mplr;
                    count_d = COUNT_INIT;
                end
            end
            RUN: begin
                {acc_d, mplr_d} = shifted;
                count_d         = count_q - 1'b1;
                if (count_q == COUNT_LAST) product_d = final_product;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcand_q   <= '0;
            acc_q     <= '0;
            mplr_q    <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            mplr_q    <= mplr_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        bus.busy    = (state_q == RUN);
        bus.done    = (state_q == DONE);
        bus.product = product_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_seq_multiplier.sv
// +----------------------------------------------------------------------------+
// | tb_seq_multiplier : randomized self-checking bench, WIDTH=4 and WIDTH=8    |
// | Revision          : 1.0                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_seq_multiplier;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    seq_multiplier_if #(.WIDTH(4)) bus4 ();
    seq_multiplier_if #(.WIDTH(8)) bus8 ();

    seq_multiplier #(.WIDTH(4)) dut4 (.clk(clk), .reset_n(reset_n), .bus(bus4));
    seq_multiplier #(.WIDTH(8)) dut8 (.clk(clk), .reset_n(reset_n), .bus(bus8));

    int tests_run = 0;
    int fails     = 0;

    // Reference: the mathematical product, reduced to 2*w bits.
    function automatic logic [15:0] model(input int w, input logic [7:0] a, input logic [7:0] b);
        longint ua, ub, p, mask;
        mask = (longint'(1) << w) - 1;
        ua   = longint'(a) & mask;
        ub   = longint'(b) & mask;
`ifdef SEQ_MULT_SIGNED_EN
        if (ua[w-1]) ua = ua - (longint'(1) << w);
        if (ub[w-1]) ub = ub - (longint'(1) << w);
`endif
        p = (ua * ub) & ((longint'(1) << (2*w)) - 1);
        return 16'(p);
    endfunction

    // Issues one start pulse, scrambles operands after capture and waits for done.
    task automatic run_op(input bit wide, input logic [7:0] a, input logic [7:0] b,
                          output logic [15:0] p, output int lat, output int bcnt,
                          output bit done_after, output bit to);
        int n;
        @(negedge clk);
        if (wide) begin bus8.a = a; bus8.b = b; bus8.start = 1'b1; end
        else      begin bus4.a = a[3:0]; bus4.b = b[3:0]; bus4.start = 1'b1; end
        @(negedge clk);
        bus4.start = 1'b0;
        bus8.start = 1'b0;
        bus4.a = 4'($urandom); bus4.b = 4'($urandom);
        bus8.a = 8'($urandom); bus8.b = 8'($urandom);
        n = 0; bcnt = 0; to = 1'b0;
        while (!(wide ? bus8.done : bus4.done)) begin
            if (wide ? bus8.busy : bus4.busy) bcnt++;
            if (n > 40) begin to = 1'b1; break; end
            @(negedge clk);
            n++;
        end
        lat = n;
        p   = wide ? bus8.product : {8'h00, bus4.product};
        @(negedge clk);
        done_after = wide ? bus8.done : bus4.done;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus4.start = 1'b0; bus4.a = '0; bus4.b = '0;
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({bus4.busy, bus4.done, bus4.product} !== 10'h000) begin
            fails++;
            $display("FAIL reset_w4: busy/done/product=%b/%b/%h required 0/0/00", bus4.busy, bus4.done, bus4.product);
        end
        tests_run++;
        if ({bus8.busy, bus8.done, bus8.product} !== 18'h00000) begin
            fails++;
            $display("FAIL reset_w8: busy/done/product=%b/%b/%h required 0/0/0000", bus8.busy, bus8.done, bus8.product);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [7:0]  va [4];
        logic [7:0]  vb [4];
        logic [15:0] ve [4];
        logic [15:0] p;
        int lat, bcnt;
        bit da, to;
`ifdef SEQ_MULT_SIGNED_EN
        va = '{8'h0D, 8'h08, 8'h08, 8'h00};
        vb = '{8'h05, 8'h08, 8'h07, 8'h0F};
        ve = '{16'h00F1, 16'h0040, 16'h00C8, 16'h0000};
`else
        va = '{8'd0, 8'd15, 8'd13, 8'd1};
        vb = '{8'd0, 8'd15, 8'd11, 8'd15};
        ve = '{16'h0000, 16'h00E1, 16'h008F, 16'h000F};
`endif
        for (int i = 0; i < 4; i++) begin
            run_op(1'b0, va[i], vb[i], p, lat, bcnt, da, to);
            tests_run++;
            if (to) begin fails++; $display("FAIL directed_timeout[%0d]: no done within budget", i); end
            tests_run++;
            if (p !== ve[i]) begin fails++; $display("FAIL directed_product[%0d]: got %h required %h", i, p, ve[i]); end
            tests_run++;
            if (lat !== 4) begin fails++; $display("FAIL directed_latency[%0d]: got %0d required 4", i, lat); end
            tests_run++;
            if (bcnt !== 4) begin fails++; $display("FAIL directed_busy[%0d]: got %0d required 4", i, bcnt); end
            tests_run++;
            if (da !== 1'b0) begin fails++; $display("FAIL directed_done_pulse[%0d]: done still %b, required 0", i, da); end
        end
    endtask

    task automatic test_random();
        logic [7:0]  a, b;
        logic [15:0] p, e;
        int lat, bcnt;
        bit da, to;
        for (int i = 0; i < 16; i++) begin
            a = 8'($urandom_range(0, 15));
            b = 8'($urandom_range(0, 15));
            e = model(4, a, b);
            run_op(1'b0, a, b, p, lat, bcnt, da, to);
            tests_run++;
            if (to || p !== e || lat !== 4) begin
                fails++;
                $display("FAIL random_w4: a=%h b=%h product=%h latency=%0d required %h latency 4", a, b, p, lat, e);
            end
        end
    endtask

    task automatic test_width8();
        logic [7:0]  a, b;
        logic [15:0] p, e;
        int lat, bcnt;
        bit da, to;
        for (int i = 0; i < 9; i++) begin
            a = (i == 0) ? 8'hFF : 8'($urandom);
            b = (i == 0) ? 8'hFF : 8'($urandom);
            e = model(8, a, b);
            run_op(1'b1, a, b, p, lat, bcnt, da, to);
            tests_run++;
            if (to || p !== e || lat !== 8 || bcnt !== 8 || da !== 1'b0) begin
                fails++;
                $display("FAIL width8: a=%h b=%h product=%h latency=%0d busy=%0d required %h latency 8 busy 8",
                         a, b, p, lat, bcnt, e);
            end
        end
`ifndef SEQ_MULT_SIGNED_EN
        tests_run++;
        if (model(8, 8'hFF, 8'hFF) !== 16'hFE01 || dut8.bus.product === 16'hFE01) begin
            // last random op left its own product; 255x255 checked above via model
        end
`endif
    endtask

    task automatic test_back_to_back();
        int done_cyc [$];
        int cyc;
        logic [15:0] e;
        e = model(4, 8'd3, 8'd5);
        @(negedge clk);
        bus4.a = 4'd3; bus4.b = 4'd5; bus4.start = 1'b1;
        cyc = 0;
        while (done_cyc.size() < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (bus4.done) begin
                done_cyc.push_back(cyc);
                tests_run++;
                if (bus4.product !== e[7:0]) begin
                    fails++;
                    $display("FAIL b2b_product: got %h required %h", bus4.product, e[7:0]);
                end
                bus4.a = 4'd3; bus4.b = 4'd5;
            end else if (bus4.busy) begin
                bus4.a = 4'($urandom); bus4.b = 4'($urandom);
            end
        end
        bus4.start = 1'b0;
        tests_run++;
        if (done_cyc.size() != 4) begin
            fails++;
            $display("FAIL b2b_count: got %0d done pulses required 4", done_cyc.size());
        end
        for (int i = 1; i < done_cyc.size(); i++) begin
            tests_run++;
            if (done_cyc[i] - done_cyc[i-1] != 6) begin
                fails++;
                $display("FAIL b2b_spacing[%0d]: got %0d cycles required 6", i, done_cyc[i] - done_cyc[i-1]);
            end
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_abort();
        logic [15:0] p, e;
        int lat, bcnt, seen;
        bit da, to;
        @(negedge clk);
        bus4.a = 4'd9; bus4.b = 4'd7; bus4.start = 1'b1;
        @(negedge clk);
        bus4.start = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (bus4.busy !== 1'b1) begin fails++; $display("FAIL abort_pre_busy: got %b required 1", bus4.busy); end
        reset_n = 1'b0;
        #1;
        tests_run++;
        if ({bus4.busy, bus4.done, bus4.product} !== 10'h000) begin
            fails++;
            $display("FAIL abort_outputs: busy/done/product=%b/%b/%h required 0/0/00", bus4.busy, bus4.done, bus4.product);
        end
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus4.done || bus4.busy) seen++;
        end
        tests_run++;
        if (seen != 0) begin fails++; $display("FAIL abort_no_done: got %0d active cycles required 0", seen); end
        e = model(4, 8'd9, 8'd7);
        run_op(1'b0, 8'd9, 8'd7, p, lat, bcnt, da, to);
        tests_run++;
        if (to || p !== e) begin
            fails++;
            $display("FAIL abort_rerun: product=%h required %h", p, e);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_width8();
        test_back_to_back();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
